// File: rtl/la_trace_expander.sv
// -----------------------------------------------------------------------------
// la_trace_expander
//
// Re-expands run-length trace beats {rc[7:0], data[23:0]} into a per-cycle
// sample stream. A beat with rc = k produces k identical samples; an all-zero
// beat is a null packet and produces a single "unknown" gap sample; a beat with
// rc = 0 but non-zero data is malformed and produces one ordinary sample.
// Saturating statistics count tlast beats, null beats and malformed beats.
//
// Handshakes (both sides): a transfer happens on a rising edge of axis_clk
// when valid and ready are both high. Valid never waits for ready. On the
// sample side, smp_data/smp_unknown/smp_last hold steady while
// smp_valid & !smp_ready. On the beat side, s_tready is a function of the
// internal state and smp_ready only, never of s_tvalid.
//
// Ports:
//   axis_clk, axis_rst_n   clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast/s_tuser   trace beat input (tuser ignored)
//   smp_data/smp_valid/smp_ready                expanded sample output
//   smp_unknown            current sample is a gap from a null beat
//   smp_last               final sample of a beat that carried tlast
//   clr_stats              synchronous clear of the counters (wins over +1)
//   pkt_count/null_count/err_count   saturating 16-bit statistics
// -----------------------------------------------------------------------------
module la_trace_expander #(
    parameter int pDATA_WIDTH   = 32,
    parameter int pSAMPLE_WIDTH = 24
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    input  logic [1:0]               s_tuser,
    output logic [pSAMPLE_WIDTH-1:0] smp_data,
    output logic                     smp_valid,
    input  logic                     smp_ready,
    output logic                     smp_unknown,
    output logic                     smp_last,
    input  logic                     clr_stats,
    output logic [15:0]              pkt_count,
    output logic [15:0]              null_count,
    output logic [15:0]              err_count
);

    localparam int RC_W = pDATA_WIDTH - pSAMPLE_WIDTH;
    localparam logic [RC_W-1:0] REM_ONE = RC_W'(1);

    // The remaining-sample counter is the FSM state; state is its decoded view.
    typedef enum logic {
        EMPTY  = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t                   state;
    logic [RC_W-1:0]          rem,         rem_nxt;
    logic [pSAMPLE_WIDTH-1:0] cur_data,    cur_data_nxt;
    logic                     cur_unknown, cur_unknown_nxt;
    logic                     cur_last,    cur_last_nxt;
    logic [15:0]              pkt_nxt, null_nxt, err_nxt;

    logic [RC_W-1:0]          beat_rc;
    logic [pSAMPLE_WIDTH-1:0] beat_smp;
    logic                     beat_null, beat_err;
    logic                     smp_hs, beat_acc;

    // s_tuser carries nothing this block needs.
    logic unused_tuser;
    assign unused_tuser = ^s_tuser;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign state       = (rem != '0) ? EXPAND : EMPTY;
    assign smp_valid   = (state == EXPAND);
    assign smp_data    = cur_data;
    assign smp_unknown = cur_unknown;
    assign smp_last    = cur_last & (rem == REM_ONE);

    // Ready when idle, or when the final pending sample leaves this cycle;
    // the combinational smp_ready path is what removes the inter-beat bubble.
    assign s_tready = (rem == '0) | ((rem == REM_ONE) & smp_ready);

    assign smp_hs   = smp_valid & smp_ready;
    assign beat_acc = s_tvalid & s_tready;

    assign beat_rc   = s_tdata[pDATA_WIDTH-1 -: RC_W];
    assign beat_smp  = s_tdata[pSAMPLE_WIDTH-1:0];
    assign beat_null = (s_tdata == '0);
    assign beat_err  = (beat_rc == '0) & ~beat_null;

    always_comb begin
        rem_nxt         = rem;
        cur_data_nxt    = cur_data;
        cur_unknown_nxt = cur_unknown;
        cur_last_nxt    = cur_last;
        pkt_nxt         = pkt_count;
        null_nxt        = null_count;
        err_nxt         = err_count;

        if (smp_hs) begin
            rem_nxt = rem - REM_ONE;
        end

        // A beat can only be accepted when rem is 0, or 1 with the last
        // sample leaving, so overriding the decrement loses nothing.
        if (beat_acc) begin
            cur_last_nxt = s_tlast;
            if (beat_null) begin
                rem_nxt         = REM_ONE;
                cur_data_nxt    = '0;
                cur_unknown_nxt = 1'b1;
                null_nxt        = sat_inc(null_count);
            end else if (beat_err) begin
                rem_nxt         = REM_ONE;
                cur_data_nxt    = beat_smp;
                cur_unknown_nxt = 1'b0;
                err_nxt         = sat_inc(err_count);
            end else begin
                rem_nxt         = beat_rc;
                cur_data_nxt    = beat_smp;
                cur_unknown_nxt = 1'b0;
            end
            if (s_tlast) begin
                pkt_nxt = sat_inc(pkt_count);
            end
        end

        if (clr_stats) begin
            pkt_nxt  = '0;
            null_nxt = '0;
            err_nxt  = '0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rem         <= '0;
            cur_data    <= '0;
            cur_unknown <= 1'b0;
            cur_last    <= 1'b0;
            pkt_count   <= '0;
            null_count  <= '0;
            err_count   <= '0;
        end else begin
            rem         <= rem_nxt;
            cur_data    <= cur_data_nxt;
            cur_unknown <= cur_unknown_nxt;
            cur_last    <= cur_last_nxt;
            pkt_count   <= pkt_nxt;
            null_count  <= null_nxt;
            err_count   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_la_trace_expander.sv
// -----------------------------------------------------------------------------
// tb_la_trace_expander
//
// Reference model: a queue of pending samples {unknown, last, data}. Each
// accepted beat appends the samples it stands for; each sample handshake pops
// the front. Counters are plain saturating integers.
// -----------------------------------------------------------------------------
module tb_la_trace_expander;

    // ---------------- clock / reset ----------------
    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    always #5 axis_clk = ~axis_clk;

    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [1:0]  s_tuser;
    logic [23:0] smp_data;
    logic        smp_valid;
    logic        smp_ready;
    logic        smp_unknown;
    logic        smp_last;
    logic        clr_stats;
    logic [15:0] pkt_count;
    logic [15:0] null_count;
    logic [15:0] err_count;

    la_trace_expander #(
        .pDATA_WIDTH  (32),
        .pSAMPLE_WIDTH(24)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tuser    (s_tuser),
        .smp_data   (smp_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .smp_unknown(smp_unknown),
        .smp_last   (smp_last),
        .clr_stats  (clr_stats),
        .pkt_count  (pkt_count),
        .null_count (null_count),
        .err_count  (err_count)
    );

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [25:0] exp_q[$];          // {unknown, last, data}
    logic [15:0] m_pkt, m_null, m_err;
    logic [25:0] obs_q[$];          // observed sample handshakes
    int          obs_cyc[$];
    int          acc_cyc;
    logic        last_acc;

    typedef struct {
        logic [31:0] tdata;
        logic        tlast;
        int          exp_n;
        logic [23:0] exp_data;
        logic        exp_unk;
        logic [15:0] exp_null;
        logic [15:0] exp_err;
        logic [15:0] exp_pkt;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_beat(input logic [31:0] d, input logic last);
        int n;
        if (d == 32'h0) begin
            exp_q.push_back({1'b1, last, 24'h0});
            m_null = sat(m_null);
        end else if (d[31:24] == 8'h0) begin
            exp_q.push_back({1'b0, last, d[23:0]});
            m_err = sat(m_err);
        end else begin
            n = int'(d[31:24]);
            for (int i = 0; i < n; i++)
                exp_q.push_back({1'b0, last && (i == n - 1), d[23:0]});
        end
        if (last) m_pkt = sat(m_pkt);
    endtask

    // One clock cycle with the inputs as currently driven. Outputs are
    // compared at the falling edge, then the model advances.
    task automatic step();
        logic exp_ready;
        logic hs;
        @(negedge axis_clk);
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && smp_ready);
        chk("smp_valid", 32'(smp_valid), 32'(exp_q.size() != 0));
        chk("s_tready", 32'(s_tready), 32'(exp_ready));
        if (exp_q.size() != 0) begin
            chk("smp_data", 32'(smp_data), 32'(exp_q[0][23:0]));
            chk("smp_unknown", 32'(smp_unknown), 32'(exp_q[0][25]));
            chk("smp_last", 32'(smp_last), 32'(exp_q[0][24]));
        end
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
        chk("null_count", 32'(null_count), 32'(m_null));
        chk("err_count", 32'(err_count), 32'(m_err));
        if (smp_valid && smp_ready) begin
            obs_q.push_back({smp_unknown, smp_last, smp_data});
            obs_cyc.push_back(cyc);
        end
        hs       = (exp_q.size() != 0) && smp_ready;
        last_acc = s_tvalid && exp_ready;
        if (last_acc) acc_cyc = cyc;
        if (hs) void'(exp_q.pop_front());
        if (last_acc) model_beat(s_tdata, s_tlast);
        if (clr_stats) begin
            m_pkt  = '0;
            m_null = '0;
            m_err  = '0;
        end
        @(posedge axis_clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [31:0] d, input logic last);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (last_acc) break;
        end
        chk("beat_accept", 32'(last_acc), 32'd1);
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        s_tvalid  = 1'b0;
        smp_ready = 1'b1;
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) step();
        step();
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
    endtask

    task automatic do_reset();
        axis_rst_n = 1'b0;
        #2;
        chk("rst_smp_valid", 32'(smp_valid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        chk("rst_smp_last", 32'(smp_last), 32'd0);
        chk("rst_smp_unknown", 32'(smp_unknown), 32'd0);
        chk("rst_smp_data", 32'(smp_data), 32'd0);
        exp_q.delete();
        m_pkt  = '0;
        m_null = '0;
        m_err  = '0;
        s_tvalid  = 1'b0;
        clr_stats = 1'b0;
        @(posedge axis_clk);
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_null_count", 32'(null_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [23:0] pre_data;
    logic        pre_valid;
    logic        pat;
    int          n5a;
    logic [7:0]  rc;

    initial begin
        vecs[0] = '{32'h0000_0000, 1'b0,   1, 24'h000000, 1'b1, 16'd1, 16'd0, 16'd0};
        vecs[1] = '{32'h0012_3456, 1'b0,   1, 24'h123456, 1'b0, 16'd0, 16'd1, 16'd0};
        vecs[2] = '{32'h03A5_A5A5, 1'b0,   3, 24'hA5A5A5, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[3] = '{32'h0100_0001, 1'b1,   1, 24'h000001, 1'b0, 16'd0, 16'd0, 16'd1};
        vecs[4] = '{32'h02FF_FFFF, 1'b1,   2, 24'hFFFFFF, 1'b0, 16'd0, 16'd0, 16'd1};
        vecs[5] = '{32'h8000_0000, 1'b0, 128, 24'h000000, 1'b0, 16'd0, 16'd0, 16'd0};
        vecs[6] = '{32'h0000_0001, 1'b1,   1, 24'h000001, 1'b0, 16'd0, 16'd1, 16'd1};

        axis_rst_n = 1'b1;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tuser    = '0;
        smp_ready  = 1'b1;
        clr_stats  = 1'b0;
        #1;
        do_reset();

        // Reset mid-expansion of an rc = 200 beat, with counters non-zero.
        send_beat(32'h0000_0000, 1'b1);
        send_beat(32'hC812_3456, 1'b0);
        for (int i = 0; i < 10; i++) step();
        do_reset();
        for (int i = 0; i < 3; i++) step();

        // Back-to-back with ready held: no bubble, last only on 4th sample.
        obs_q.delete(); obs_cyc.delete();
        smp_ready = 1'b1;
        send_beat(32'h03A5_A5A5, 1'b0);
        send_beat(32'h0100_0001, 1'b1);
        chk("b2b_accept_cycle", 32'(acc_cyc), 32'(obs_cyc[2]));
        drain();
        chk("b2b_count", 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_data", 32'(obs_q[i][23:0]), (i < 3) ? 32'hA5A5A5 : 32'h000001);
            chk("b2b_last", 32'(obs_q[i][24]), 32'(i == 3));
            chk("b2b_no_bubble", 32'(obs_cyc[i]), 32'(obs_cyc[0] + i));
        end
        chk("b2b_pkt_count", 32'(pkt_count), 32'd1);

        // Back-pressure with ready pattern 1,0,0,1,...
        obs_q.delete(); obs_cyc.delete();
        send_beat(32'h0500_BEEF, 1'b1);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            pat       = (k % 4 == 0) || (k % 4 == 3);
            smp_ready = pat;
            pre_data  = smp_data;
            pre_valid = smp_valid;
            step();
            if (pre_valid && !pat) chk("stall_stable", 32'(smp_data), 32'(pre_data));
        end
        drain();
        chk("bp_count", 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 32'(obs_q[i][23:0]), 32'h00BEEF);
            chk("bp_last", 32'(obs_q[i][24]), 32'(i == 4));
        end

        // Null then malformed beat.
        clear_stats();
        obs_q.delete(); obs_cyc.delete();
        send_beat(32'h0000_0000, 1'b0);
        send_beat(32'h0012_3456, 1'b0);
        drain();
        chk("nm_count", 32'(obs_q.size()), 32'd2);
        chk("nm_null_sample", 32'(obs_q[0]), 32'({1'b1, 1'b0, 24'h000000}));
        chk("nm_err_sample", 32'(obs_q[1]), 32'({1'b0, 1'b0, 24'h123456}));
        chk("nm_null_count", 32'(null_count), 32'd1);
        chk("nm_err_count", 32'(err_count), 32'd1);

        // Table of isolated beats.
        for (int v = 0; v < 7; v++) begin
            clear_stats();
            obs_q.delete(); obs_cyc.delete();
            send_beat(vecs[v].tdata, vecs[v].tlast);
            drain();
            chk("vec_count", 32'(obs_q.size()), 32'(vecs[v].exp_n));
            for (int i = 0; i < obs_q.size(); i++) begin
                chk("vec_data", 32'(obs_q[i][23:0]), 32'(vecs[v].exp_data));
                chk("vec_unknown", 32'(obs_q[i][25]), 32'(vecs[v].exp_unk));
                chk("vec_last", 32'(obs_q[i][24]),
                    32'(vecs[v].tlast && (i == vecs[v].exp_n - 1)));
            end
            chk("vec_null_count", 32'(null_count), 32'(vecs[v].exp_null));
            chk("vec_err_count", 32'(err_count), 32'(vecs[v].exp_err));
            chk("vec_pkt_count", 32'(pkt_count), 32'(vecs[v].exp_pkt));
        end

        // Maximum run, next beat taken on the 255th handshake.
        obs_q.delete(); obs_cyc.delete();
        smp_ready = 1'b1;
        send_beat(32'hFF5A_5A5A, 1'b0);
        send_beat(32'h0211_1111, 1'b0);
        drain();
        n5a = 0;
        foreach (obs_q[i]) if (obs_q[i][23:0] == 24'h5A5A5A) n5a++;
        chk("max_run_count", 32'(n5a), 32'd255);
        chk("max_run_total", 32'(obs_q.size()), 32'd257);
        chk("max_run_next_accept", 32'(acc_cyc), 32'(obs_cyc[254]));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            s_tvalid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0:       s_tdata = 32'h0;
                1:       s_tdata = {8'h00, 24'($urandom_range(0, 15))};
                2:       begin rc = 8'($urandom_range(7, 40)); s_tdata = {rc, 24'($urandom)}; end
                default: begin rc = 8'($urandom_range(1, 6));  s_tdata = {rc, 24'($urandom)}; end
            endcase
            s_tlast   = ($urandom_range(0, 2) == 0);
            s_tuser   = 2'($urandom_range(0, 3));
            smp_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 63) == 0);
            step();
        end
        clr_stats = 1'b0;
        drain();

        // Null counter saturation, then clear racing an increment.
        clear_stats();
        smp_ready = 1'b1;
        s_tvalid  = 1'b1;
        s_tdata   = 32'h0;
        s_tlast   = 1'b0;
        for (int i = 0; i < 65537; i++) step();
        chk("sat_null_count", 32'(null_count), 32'h0000FFFF);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        s_tvalid  = 1'b0;
        drain();
        chk("clr_null_count", 32'(null_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
